// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_BAD  = 4'b1111
  } alu_ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Maps func3/func7_5 to an ALU operation code for R-type and I-type ops.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic      [2:0] i_func3,
  input  logic            i_func7_5,
  input  logic            i_is_rtype,
  output alu_ctrl_t       o_alu_control,
  output logic            o_illegal
);

  // Decode the operation; bit 30 only selects SUB (R-type) and SRA/SRAI,
  // and is illegal with any other R-type func3.
  always_comb begin
    o_alu_control = ALU_BAD;
    o_illegal     = 1'b0;
    case (i_func3)
      3'b000:  o_alu_control = (i_is_rtype && i_func7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  o_alu_control = ALU_SLL;
      3'b010:  o_alu_control = ALU_SLT;
      3'b011:  o_alu_control = ALU_SLTU;
      3'b100:  o_alu_control = ALU_XOR;
      3'b101:  o_alu_control = i_func7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  o_alu_control = ALU_OR;
      default: o_alu_control = ALU_AND;
    endcase
    if (i_is_rtype && i_func7_5 && (i_func3 != 3'b000) && (i_func3 != 3'b101)) begin
      o_alu_control = ALU_BAD;
      o_illegal     = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM with a memory handshake, wait-state
// timeout and a sticky trap.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_func3,
  input  logic       i_func7_5,
  input  logic       i_alu_zero,
  input  logic       i_mem_ack,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_adr_source,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_imm_source,
  output logic [1:0] o_result_source,
  output logic [3:0] o_alu_control,
  output logic       o_trap
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t          r_state;
  state_t          w_next;
  logic   [CW-1:0] r_wait_cnt;
  logic            w_is_req_state;
  logic            w_timeout;
  logic            w_is_rtype;
  alu_ctrl_t       w_dec_alu;
  logic            w_dec_illegal;

  assign w_is_rtype     = (r_state == S_EXEC_R);
  assign w_is_req_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);
  assign w_timeout      = (MEM_TIMEOUT != 0) && (r_wait_cnt == CW'(MEM_TIMEOUT));

  alu_decoder u_alu_decoder (
    .i_func3       (i_func3),
    .i_func7_5     (i_func7_5),
    .i_is_rtype    (w_is_rtype),
    .o_alu_control (w_dec_alu),
    .o_illegal     (w_dec_illegal)
  );

  // State register; reset abandons any instruction and restarts at FETCH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait-state counter: counts unacknowledged request cycles, clears on ack
  // or on leaving the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if ((MEM_TIMEOUT == 0) || !w_is_req_state || i_mem_ack || (w_next != r_state)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  // Next-state and output decode; everything is forced low while in reset.
  always_comb begin
    w_next          = r_state;
    o_mem_req       = 1'b0;
    o_mem_write     = 1'b0;
    o_adr_source    = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = SRC_A_PC;
    o_alu_src_b     = SRC_B_RS2;
    o_imm_source    = IMM_I;
    o_result_source = RES_ALUOUT;
    o_alu_control   = ALU_ADD;
    o_trap          = 1'b0;

    case (r_state)
      S_FETCH: begin
        o_mem_req       = 1'b1;
        o_alu_src_b     = SRC_B_FOUR;
        o_result_source = RES_ALURESULT;
        if (i_mem_ack) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        o_alu_src_a  = SRC_A_OLDPC;
        o_alu_src_b  = SRC_B_IMM;
        o_imm_source = (i_op == OP_JAL) ? IMM_J : IMM_B;
        case (i_op)
          OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
          OP_RTYPE:          w_next = S_EXEC_R;
          OP_ITYPE:          w_next = S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        o_alu_src_a  = SRC_A_RS1;
        o_alu_src_b  = SRC_B_IMM;
        o_imm_source = (i_op == OP_STORE) ? IMM_S : IMM_I;
        w_next       = (i_op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        o_mem_req    = 1'b1;
        o_adr_source = 1'b1;
        if (i_mem_ack) begin
          w_next = S_MEM_WB;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_MEM_WB: begin
        o_result_source = RES_MEMDATA;
        o_reg_write     = 1'b1;
        w_next          = S_FETCH;
      end
      S_MEM_WRITE: begin
        o_mem_req    = 1'b1;
        o_mem_write  = 1'b1;
        o_adr_source = 1'b1;
        if (i_mem_ack) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_EXEC_R: begin
        o_alu_src_a   = SRC_A_RS1;
        o_alu_src_b   = SRC_B_RS2;
        o_alu_control = w_dec_alu;
        w_next        = w_dec_illegal ? S_TRAP : S_ALU_WB;
      end
      S_EXEC_I: begin
        o_alu_src_a   = SRC_A_RS1;
        o_alu_src_b   = SRC_B_IMM;
        o_imm_source  = IMM_I;
        o_alu_control = w_dec_alu;
        w_next        = w_dec_illegal ? S_TRAP : S_ALU_WB;
      end
      S_ALU_WB: begin
        o_result_source = RES_ALUOUT;
        o_reg_write     = 1'b1;
        w_next          = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a     = SRC_A_RS1;
        o_alu_src_b     = SRC_B_RS2;
        o_alu_control   = ALU_SUB;
        o_result_source = RES_ALUOUT;
        case (i_func3)
          3'b000: begin
            o_pc_write = i_alu_zero;
            w_next     = S_FETCH;
          end
          3'b001: begin
            o_pc_write = !i_alu_zero;
            w_next     = S_FETCH;
          end
          default: w_next = S_TRAP;
        endcase
      end
      S_JAL: begin
        o_alu_src_a     = SRC_A_OLDPC;
        o_alu_src_b     = SRC_B_FOUR;
        o_result_source = RES_ALUOUT;
        o_pc_write      = 1'b1;
        w_next          = S_ALU_WB;
      end
      S_TRAP: begin
        o_trap = 1'b1;
      end
      default: w_next = S_TRAP;
    endcase

    if (!i_rst_n) begin
      o_mem_req       = 1'b0;
      o_mem_write     = 1'b0;
      o_adr_source    = 1'b0;
      o_ir_write      = 1'b0;
      o_pc_write      = 1'b0;
      o_reg_write     = 1'b0;
      o_alu_src_a     = 2'b00;
      o_alu_src_b     = 2'b00;
      o_imm_source    = 3'b000;
      o_result_source = 2'b00;
      o_alu_control   = 4'b0000;
      o_trap          = 1'b0;
    end
  end

endmodule
